ccd_stream_gen: RTL



---
 rtl/ccd_stream_pkg.sv | 24 ++
 rtl/ccd_pattern_rom.sv | 24 ++
 rtl/ccd_stream_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ccd_stream_pkg.sv
// Shared types and widths for the synthetic CCD stream source.
package ccd_stream_pkg;

  localparam int DATA_W = 10;
  localparam int CNT_W  = 16;

  // Frame-level phases of the generator
  typedef enum logic [2:0] {
    IDLE,
    GAP,
    PRE,
    ACTIVE,
    POST
  } state_t;

  // Pixel data patterns selectable per frame
  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_BAYER = 2'd2,
    PAT_FTAG  = 2'd3
  } pattern_t;

endpackage

// File: rtl/ccd_pattern_rom.sv
// Combinational pixel-value generator for the selected test pattern.
// Only the low coordinate bits that any pattern uses are brought in.
module ccd_pattern_rom
  import ccd_stream_pkg::*;
(
  input  pattern_t            pattern,
  input  logic [DATA_W-1:0]   x_lo,
  input  logic [DATA_W-1:0]   y_lo,
  input  logic [1:0]          frame_lo,
  output logic [DATA_W-1:0]   pix_data
);

  // Select the pixel value for the current coordinates
  always_comb begin
    pix_data = '0;
    case (pattern)
      PAT_HRAMP: pix_data = x_lo;
      PAT_VRAMP: pix_data = y_lo;
      PAT_BAYER: pix_data = (x_lo[0] ^ y_lo[0]) ? '1 : '0;
      PAT_FTAG:  pix_data = {frame_lo, x_lo[7:0]};
    endcase
  end

endmodule

// File: rtl/ccd_stream_gen.sv
// Synthetic D8M sensor-side stream source (FVAL/LVAL/DATA/X/Y/frame count).
// Next-cycle values are computed combinationally and registered together,
// so every output changes on the same edge with no skew between them.
module ccd_stream_gen
  import ccd_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_PRE    = 4,
  parameter int unsigned V_POST   = 4,
  parameter int unsigned F_GAP    = 16
) (
  input  logic               CCD_PIXCLK,
  input  logic               RESET_N,
  input  logic               EN,
  input  logic [1:0]         PATTERN,
  output logic               mCCD_FVAL,
  output logic               mCCD_LVAL,
  output logic [DATA_W-1:0]  mCCD_DATA,
  output logic [CNT_W-1:0]   X_Cont,
  output logic [CNT_W-1:0]   Y_Cont,
  output logic [CNT_W-1:0]   FRAME_Cont
);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_BLANK - 1);
  localparam logic [CNT_W-1:0] H_ACT_W    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  // PRE_LAST wraps when V_PRE is 0, but PRE is never entered in that case
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(F_GAP - 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(V_PRE - 1);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(V_POST - 1);

  state_t             state_reg, state_next;
  pattern_t           pat_reg, pat_next;
  logic [CNT_W-1:0]   h_reg, h_next;
  logic [CNT_W-1:0]   line_reg, line_next;
  logic [CNT_W-1:0]   x_reg, x_next;
  logic [CNT_W-1:0]   y_reg, y_next;
  logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               fval_reg, fval_next;
  logic               lval_reg, lval_next;
  logic               h_last;
  logic [DATA_W-1:0]  rom_data;

  assign h_last = (h_reg == H_LAST);

  // Sequencing: line timing, frame phases, and the counters shown on the outputs
  always_comb begin
    state_next     = state_reg;
    pat_next       = pat_reg;
    h_next         = h_last ? '0 : h_reg + CNT_W'(1);
    line_next      = h_last ? line_reg + CNT_W'(1) : line_reg;
    fval_next      = fval_reg;
    y_next         = y_reg;
    frame_cnt_next = frame_cnt_reg;

    case (state_reg)
      IDLE: begin
        h_next    = '0;
        line_next = '0;
        fval_next = 1'b0;
        y_next    = '0;
        if (EN) state_next = GAP;
      end
      GAP: begin
        if (h_last && line_reg == GAP_LAST) begin
          line_next = '0;
          y_next    = '0;
          if (EN) begin
            state_next = (V_PRE == 0) ? ACTIVE : PRE;
            fval_next  = 1'b1;
            pat_next   = pattern_t'(PATTERN);
          end else begin
            state_next = IDLE;
          end
        end
      end
      PRE: begin
        if (h_last && line_reg == PRE_LAST) begin
          line_next  = '0;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // Line index advances on the edge where LVAL falls
        if (h_reg == H_ACT_LAST) y_next = y_reg + CNT_W'(1);
        if (h_last && line_reg == ACT_LAST) begin
          line_next  = '0;
          state_next = POST;
        end
      end
      POST: begin
        if (h_last && line_reg == POST_LAST) begin
          line_next      = '0;
          state_next     = GAP;
          fval_next      = 1'b0;
          frame_cnt_next = frame_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    lval_next = (state_next == ACTIVE) && (h_next < H_ACT_W);
    x_next    = lval_next ? h_next : '0;
  end

  ccd_pattern_rom u_pattern_rom (
    .pattern  (pat_next),
    .x_lo     (x_next[DATA_W-1:0]),
    .y_lo     (y_next[DATA_W-1:0]),
    .frame_lo (frame_cnt_reg[1:0]),
    .pix_data (rom_data)
  );

  assign data_next = lval_next ? rom_data : '0;

  // FSM and registered outputs; reset clears everything including the frame count
  always_ff @(posedge CCD_PIXCLK) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      pat_reg       <= PAT_HRAMP;
      h_reg         <= '0;
      line_reg      <= '0;
      fval_reg      <= 1'b0;
      lval_reg      <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      data_reg      <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pat_reg       <= pat_next;
      h_reg         <= h_next;
      line_reg      <= line_next;
      fval_reg      <= fval_next;
      lval_reg      <= lval_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      data_reg      <= data_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign mCCD_FVAL  = fval_reg;
  assign mCCD_LVAL  = lval_reg;
  assign mCCD_DATA  = data_reg;
  assign X_Cont     = x_reg;
  assign Y_Cont     = y_reg;
  assign FRAME_Cont = frame_cnt_reg;

endmodule
